// File: rtl/cpu_control_sequencer.sv
// Microcoded control sequencer for an 8-bit breadboard-style CPU.
// Five microsteps per instruction at most; the control word is decoded
// combinationally from the current step, opcode, flags, enable and halt.
module cpu_control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  t_state,
  output logic        halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  logic [2:0]  r_t_state;
  logic        r_halted;
  logic [2:0]  w_last_step;
  logic [15:0] w_ctrl;

  // Last microstep used by each opcode; everything not listed ends at T2.
  always_comb begin
    w_last_step = 3'd2;
    case (opcode)
      4'b0001, 4'b0100: w_last_step = 3'd3;
      4'b0010, 4'b0011: w_last_step = 3'd4;
      default:          w_last_step = 3'd2;
    endcase
  end

  // Control word decode; halt overrides everything, en=0 gives an idle word.
  always_comb begin
    w_ctrl = 16'h0000;
    if (r_halted) begin
      w_ctrl = C_HLT;
    end else if (en) begin
      case (r_t_state)
        3'd0: w_ctrl = C_CO | C_MI;
        3'd1: w_ctrl = C_RO | C_II | C_CE;
        3'd2: begin
          case (opcode)
            4'b0001, 4'b0010,
            4'b0011, 4'b0100: w_ctrl = C_IO | C_MI;
            4'b0101:          w_ctrl = C_IO | C_AI;
            4'b0110:          w_ctrl = C_IO | C_J;
            4'b0111:          w_ctrl = carry_flag ? (C_IO | C_J) : 16'h0000;
            4'b1000:          w_ctrl = zero_flag  ? (C_IO | C_J) : 16'h0000;
            4'b1110:          w_ctrl = C_AO | C_OI;
            4'b1111:          w_ctrl = C_HLT;
            default:          w_ctrl = 16'h0000;
          endcase
        end
        3'd3: begin
          case (opcode)
            4'b0001:          w_ctrl = C_RO | C_AI;
            4'b0010, 4'b0011: w_ctrl = C_RO | C_BI;
            4'b0100:          w_ctrl = C_AO | C_RI;
            default:          w_ctrl = 16'h0000;
          endcase
        end
        3'd4: begin
          case (opcode)
            4'b0010: w_ctrl = C_EO | C_AI | C_FI;
            4'b0011: w_ctrl = C_EO | C_SU | C_AI | C_FI;
            default: w_ctrl = 16'h0000;
          endcase
        end
        default: w_ctrl = 16'h0000;
      endcase
    end
  end

  // Step counter and halt latch; a step at or past the opcode's last step
  // (including illegal 5..7) wraps to T0 so a stray state recovers in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_state <= 3'd0;
      r_halted  <= 1'b0;
    end else if (r_halted) begin
      r_t_state <= 3'd0;
    end else if (en) begin
      if (r_t_state == 3'd2 && opcode == 4'b1111) begin
        r_halted  <= 1'b1;
        r_t_state <= 3'd0;
      end else if (r_t_state >= w_last_step) begin
        r_t_state <= 3'd0;
      end else begin
        r_t_state <= r_t_state + 3'd1;
      end
    end
  end

  assign ctrl    = w_ctrl;
  assign t_state = r_t_state;
  assign halted  = r_halted;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        carry_flag = 1'b0;
  logic        zero_flag = 1'b0;
  logic [15:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .ctrl(ctrl), .t_state(t_state), .halted(halted)
  );

  always #5 clk = ~clk;

  // Microprogram of each instruction as a list of words; step index 0..len-1.
  function automatic int prog_len(input logic [3:0] op);
    case (op)
      4'd1, 4'd4: return 4;
      4'd2, 4'd3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [15:0] prog_word(input logic [3:0] op, input int idx,
                                            input logic c, input logic z);
    logic [15:0] w [5];
    w[0] = 16'h4004; w[1] = 16'h1408; w[2] = 16'h0; w[3] = 16'h0; w[4] = 16'h0;
    case (op)
      4'd1:  begin w[2] = 16'h4800; w[3] = 16'h1200; end
      4'd2:  begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h0281; end
      4'd3:  begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h02C1; end
      4'd4:  begin w[2] = 16'h4800; w[3] = 16'h2100; end
      4'd5:  w[2] = 16'h0A00;
      4'd6:  w[2] = 16'h0802;
      4'd7:  w[2] = c ? 16'h0802 : 16'h0000;
      4'd8:  w[2] = z ? 16'h0802 : 16'h0000;
      4'd14: w[2] = 16'h0110;
      4'd15: w[2] = 16'h8000;
      default: ;
    endcase
    if (idx < 0 || idx > 4) return 16'h0;
    return w[idx];
  endfunction

  // Reference model: position within the current instruction plus halt bit.
  int   m_step;
  logic m_halt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt && en) begin
      if (opcode == 4'd15 && m_step == 2) begin
        m_halt <= 1'b1;
        m_step <= 0;
      end else if (m_step + 1 >= prog_len(opcode)) begin
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_drivers(input logic [15:0] w);
    logic [15:0] b;
    b = w & 16'h1984;
    return $countones(b);
  endfunction

  task automatic model_compare();
    logic [15:0] e;
    if (m_halt)   e = 16'h8000;
    else if (!en) e = 16'h0000;
    else          e = prog_word(opcode, m_step, carry_flag, zero_flag);
    chk("model_ctrl", ctrl, e);
    chk("model_t_state", t_state, m_step);
    chk("model_halted", halted, m_halt);
    n_checks++;
    if (n_drivers(ctrl) > 1) begin
      n_fail++;
      $display("FAIL bus_drivers: got %0d drivers in 0x%0h, expected at most 1", n_drivers(ctrl), ctrl);
    end
  endtask

  // One clock: compare against the model mid-cycle, then step past the edge.
  task automatic cyc();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_len(input logic [3:0] op, input int n);
    opcode = op;
    #1;
    chk("start_t0", t_state, 0);
    cycn(n - 1);
    chk("before_last_not_t0", (t_state != 0) ? 1 : 0, 1);
    cyc();
    chk("instr_len", t_state, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst_t", t_state, 0);
    chk("async_rst_h", halted, 0);
    chk("async_rst_ctrl", ctrl, en ? 16'h4004 : 16'h0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    en = 1'b1;
    #2;
    chk("rst_ctrl_en1", ctrl, 16'h4004);
    en = 1'b0;
    #1;
    chk("rst_ctrl_en0", ctrl, 16'h0000);
    chk("rst_t", t_state, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    en = 1'b1;
    opcode = 4'd2;
    #1;

    // ADD: full literal sequence
    chk("add_t0", ctrl, 16'h4004); cyc();
    chk("add_t1", ctrl, 16'h1408); chk("add_t1_t", t_state, 1); cyc();
    chk("add_t2", ctrl, 16'h4800); chk("add_t2_t", t_state, 2); cyc();
    chk("add_t3", ctrl, 16'h1020); chk("add_t3_t", t_state, 3); cyc();
    chk("add_t4", ctrl, 16'h0281); chk("add_t4_t", t_state, 4); cyc();
    chk("add_end", t_state, 0);

    opcode = 4'd3; cycn(4); chk("sub_t4", ctrl, 16'h02C1); cyc();
    opcode = 4'd1; cycn(3); chk("lda_t3", ctrl, 16'h1200); cyc(); chk("lda_end", t_state, 0);
    opcode = 4'd4; cycn(3); chk("sta_t3", ctrl, 16'h2100); cyc();

    // Conditional jumps; flags toggled during fetch must not matter
    opcode = 4'd7; carry_flag = 1'b1; cycn(2); carry_flag = 1'b0; #1;
    chk("jc_nc", ctrl, 16'h0000); cyc(); chk("jc_nc_end", t_state, 0);
    cycn(2); carry_flag = 1'b1; #1; chk("jc_c", ctrl, 16'h0802); cyc();
    opcode = 4'd8; zero_flag = 1'b1; cycn(2); zero_flag = 1'b0; #1;
    chk("jz_nz", ctrl, 16'h0000); cyc(); chk("jz_nz_end", t_state, 0);
    cycn(2); zero_flag = 1'b1; #1; chk("jz_z", ctrl, 16'h0802); cyc();
    zero_flag = 1'b0;

    // Lengths, including undefined opcodes 1001..1101
    for (int op = 9; op <= 13; op++) begin
      opcode = op[3:0]; cycn(2); chk("undef_t2", ctrl, 16'h0000); cyc();
      chk("undef_len", t_state, 0);
    end
    run_len(4'd0, 3); run_len(4'd5, 3); run_len(4'd6, 3); run_len(4'd14, 3);
    run_len(4'd1, 4); run_len(4'd4, 4); run_len(4'd2, 5); run_len(4'd3, 5);

    // Freeze in T3 of ADD, resume, then abort in T4
    opcode = 4'd2; cycn(3);
    en = 1'b0; #1; chk("frz_ctrl", ctrl, 16'h0000);
    cycn(3); chk("frz_t", t_state, 3);
    en = 1'b1; #1; chk("resume_ctrl", ctrl, 16'h1020);
    cyc(); chk("resume_t4", t_state, 4);
    pulse_reset();
    cyc(); chk("post_rst_t1", t_state, 1);
    cycn(4);

    // Halt
    opcode = 4'd15; cycn(2); chk("hlt_t2", ctrl, 16'h8000); cyc();
    chk("hlt_set", halted, 1); chk("hlt_t", t_state, 0);
    for (int i = 0; i < 10; i++) begin
      en = i[0]; opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1)); zero_flag = 1'($urandom_range(0, 1));
      #1; chk("halted_ctrl", ctrl, 16'h8000);
      cyc();
    end
    chk("halted_t", t_state, 0);
    en = 1'b1;
    pulse_reset();
    chk("unhalt_ctrl", ctrl, 16'h4004);
    opcode = 4'd6; cycn(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
CPU_CONTROL_SEQUENCER -- requirements
Module: cpu_control_sequencer

Interface
REQ-001 The block SHALL have no parameters; the step count, opcode map and control-word layout are fixed.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  advance enable; 1 = execute the current step and advance, 0 = freeze.
REQ-005 opcode  input  4  upper nibble of the instruction register; stable from T2 onward.
REQ-006 carry_flag  input  1  ALU carry flag, used by JC.
REQ-007 zero_flag  input  1  ALU zero flag, used by JZ.
REQ-008 ctrl  output  16  control word driven to the datapath: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
REQ-009 t_state  output  3  current microstep, 0..4.
REQ-010 halted  output  1  high once HLT has executed.

Function
REQ-011 The only state SHALL be the registered t_state and halted; ctrl SHALL be combinational from t_state, opcode, flags, en and halted.
REQ-012 When en=0 and halted=0, ctrl SHALL be 0x0000 and all state SHALL hold.
REQ-013 Fetch: T0 ctrl SHALL be CO|MI (0x4004); T1 ctrl SHALL be RO|II|CE (0x1408), independent of opcode.
REQ-014 Execute micro-ops (T2 / T3 / T4; "-" = step not used):
  0000 NOP: 0 / - / -
  0001 LDA: IO|MI / RO|AI / -
  0010 ADD: IO|MI / RO|BI / EO|AI|FI
  0011 SUB: IO|MI / RO|BI / EO|SU|AI|FI
  0100 STA: IO|MI / AO|RI / -
  0101 LDI: IO|AI / - / -
  0110 JMP: IO|J / - / -
  0111 JC: IO|J if carry_flag=1, else 0 / - / -
  1000 JZ: IO|J if zero_flag=1, else 0 / - / -
  1110 OUT: AO|OI / - / -
  1111 HLT: HLT / - / -
  all other opcodes: same as NOP.
REQ-015 Advance rule on rising clk with en=1: if the current step is the last used step of the opcode, t_state SHALL go to 0; otherwise it SHALL increment by 1.
REQ-016 Instruction lengths SHALL therefore be: NOP, undefined, LDI, JMP, JC, JZ, OUT and HLT 3 cycles; LDA and STA 4; ADD and SUB 5.
REQ-017 A conditional jump SHALL sample the flag combinationally during T2 only; a flag change in T0/T1 SHALL NOT matter.
REQ-018 On a rising edge in T2 with en=1 and opcode=1111, halted SHALL set to 1 and t_state SHALL go to 0.
REQ-019 While halted=1: ctrl SHALL be 0x8000 regardless of en, opcode and flags; t_state SHALL stay 0; only rst_n clears halted.
REQ-020 t_state SHALL never take the values 5..7; if it does, the next enabled edge SHALL force it to 0 with ctrl=0x0000 in the meantime.
REQ-021 ctrl SHALL be one-hot-free of conflicts: at most one bus driver (RO, IO, AO, EO, CO) SHALL be asserted in any step.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, force t_state=0 and halted=0, so that ctrl=0x4004 if en=1 and 0x0000 if en=0.
REQ-023 Reset asserted mid-instruction, including during T3/T4 of ADD or while halted, SHALL abort it; the first enabled edge after release SHALL move T0 to T1.
REQ-024 Release of rst_n SHALL be synchronous to clk externally; the block SHALL NOT require a minimum reset width beyond one clk period.

Verification
REQ-025 Reset then en=1, opcode=0010, four edges -> ctrl sequence 0x4004, 0x1408, 0x4800, 0x1020, 0x0281; t_state 0,1,2,3,4; after the fifth edge t_state=0.
REQ-026 opcode=0011 -> T4 ctrl=0x02C1; opcode=0001 -> T3 ctrl=0x1200, next edge t_state=0; opcode=0100 -> T3 ctrl=0x2100.
REQ-027 opcode=0111 with carry_flag=0 -> T2 ctrl=0x0000, then t_state=0; with carry_flag=1 -> T2 ctrl=0x0802. The same applies to opcode=1000 using zero_flag.
REQ-028 opcode=1111 -> T2 ctrl=0x8000; after that edge halted=1 and t_state=0; ten more edges with en toggling -> ctrl stays 0x8000; pulsing rst_n low -> halted=0 and ctrl=0x4004 without a clock edge.
REQ-029 In T3 of ADD, drive en=0 for 3 edges -> ctrl=0x0000 and t_state=3 held; then en=1 -> ctrl=0x1020 resumes. rst_n low in T4 -> t_state=0 asynchronously.
REQ-030 Sweep opcodes 1001..1101 -> T2 ctrl=0x0000 and the instruction completes in 3 cycles; every step of every opcode is checked for at most one bus driver.
